// File: rtl/mconst_fetch_if.sv
// Handshake and byte-memory bundle between mconst_fetch, program memory
// and the MCONST constant input.
interface mconst_fetch_if #(
   parameter int ADDR_WIDTH = 16
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic                  busy;
   logic                  mem_rd;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [7:0]            mem_data;
   logic [31:0]           const_out;
   logic                  const_valid;
   logic                  const_ready;

   modport slave (
      input  start, base_addr, mem_data, const_ready,
      output busy, mem_rd, mem_addr, const_out, const_valid
   );

   modport master (
      output start, base_addr, mem_data, const_ready,
      input  busy, mem_rd, mem_addr, const_out, const_valid
   );
endinterface

// File: rtl/mconst_fetch.sv
// Four-beat byte fetch of a 32-bit constant for MCONST, valid/ready output.
// Define MCONST_FETCH_BIG_ENDIAN_EN to place byte base+0 in const_out[31:24].
module mconst_fetch #(
   parameter int ADDR_WIDTH = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   mconst_fetch_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

   state_t                state, state_n;
   logic [1:0]            k, k_n;
   logic [1:0]            lane;
   logic                  rd_q, rd_n;
   logic [ADDR_WIDTH-1:0] addr_q, addr_n;
   logic [31:0]           word_q, word_n;
   logic                  busy_q;
   logic                  valid_q;

`ifdef MCONST_FETCH_BIG_ENDIAN_EN
   assign lane = ~k;
`else
   assign lane = k;
`endif

   // k is the byte being read this cycle; it is captured at the closing edge
   always_comb begin
      state_n = state;
      k_n     = k;
      rd_n    = rd_q;
      addr_n  = addr_q;
      word_n  = word_q;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_n = FETCH;
               k_n     = 2'd0;
               rd_n    = 1'b1;
               addr_n  = bus.base_addr;
            end
         end
         FETCH: begin
            word_n[{lane, 3'b000} +: 8] = bus.mem_data;
            if (k == 2'd3) begin
               state_n = HOLD;
               rd_n    = 1'b0;
            end else begin
               k_n    = k + 2'd1;
               addr_n = addr_q + ONE;
            end
         end
         HOLD: begin
            if (bus.const_ready) begin
               if (bus.start) begin
                  state_n = FETCH;
                  k_n     = 2'd0;
                  rd_n    = 1'b1;
                  addr_n  = bus.base_addr;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         k       <= 2'd0;
         rd_q    <= 1'b0;
         addr_q  <= '0;
         word_q  <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state   <= state_n;
         k       <= k_n;
         rd_q    <= rd_n;
         addr_q  <= addr_n;
         word_q  <= word_n;
         busy_q  <= (state_n != IDLE);
         valid_q <= (state_n == HOLD);
      end
   end

   assign bus.busy        = busy_q;
   assign bus.mem_rd      = rd_q;
   assign bus.mem_addr    = addr_q;
   assign bus.const_out   = word_q;
   assign bus.const_valid = valid_q;
endmodule

// File: tb/tb_mconst_fetch.sv
// Bench for mconst_fetch: fetch-level reference model plus directed vectors.
// Build with MCONST_FETCH_BIG_ENDIAN_EN to exercise the big-endian variant.
module tb_mconst_fetch;
   localparam int AW = 16;

   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   mconst_fetch_if #(.ADDR_WIDTH(AW)) bus ();

   mconst_fetch #(.ADDR_WIDTH(AW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   logic [7:0] mem [0:65535];
   assign bus.mem_data = mem[bus.mem_addr];

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // bit offset of the i-th fetched byte inside the constant
   function automatic int pos(input int i);
`ifdef MCONST_FETCH_BIG_ENDIAN_EN
      return 8 * (3 - i);
`else
      return 8 * i;
`endif
   endfunction

   // phase: 0 idle, 1..4 reading byte phase-1, 5 presenting
   int          m_phase;
   logic [15:0] m_base;
   logic [31:0] m_word;

   function automatic logic [15:0] maddr(input logic [15:0] b, input int p);
      return 16'(b + 16'(p - 1));
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_phase <= 0;
         m_base  <= '0;
         m_word  <= '0;
      end else if (m_phase == 0) begin
         if (bus.start) begin
            m_base  <= bus.base_addr;
            m_phase <= 1;
         end
      end else if (m_phase < 5) begin
         m_word[pos(m_phase - 1) +: 8] <= mem[maddr(m_base, m_phase)];
         m_phase <= m_phase + 1;
      end else if (bus.const_ready) begin
         if (bus.start) begin
            m_base  <= bus.base_addr;
            m_phase <= 1;
         end else begin
            m_phase <= 0;
         end
      end
   end

   int          cyc = 0;
   int          rd_cnt = 0;
   logic        pv = 1'b0;
   logic [15:0] alog [$];
   int          vrise [$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      chk("busy", 32'(bus.busy), 32'(m_phase != 0));
      chk("mem_rd", 32'(bus.mem_rd), 32'(m_phase >= 1 && m_phase <= 4));
      if (m_phase >= 1 && m_phase <= 4)
         chk("mem_addr", 32'(bus.mem_addr), 32'(maddr(m_base, m_phase)));
      chk("const_valid", 32'(bus.const_valid), 32'(m_phase == 5));
      chk("const_out", bus.const_out, m_word);
      if (bus.mem_rd) begin
         rd_cnt <= rd_cnt + 1;
         alog.push_back(bus.mem_addr);
      end
      if (bus.const_valid && !pv) vrise.push_back(cyc);
      pv <= bus.const_valid;
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 20 && !bus.const_valid; i++) step();
      chk("valid_timeout", 32'(bus.const_valid), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no end, want finish");
      $fatal(1, "watchdog");
   end

   logic [31:0] e_le, e_b2b, e_wrap, e_rst, held;
   logic [15:0] wexp [4];
   int c0, r0, v1, nr;

   initial begin
`ifdef MCONST_FETCH_BIG_ENDIAN_EN
      e_le   = 32'h122F8F1C;
      e_b2b  = 32'hA1B2C3D4;
      e_wrap = 32'h55667788;
      e_rst  = 32'h18966F3E;
`else
      e_le   = 32'h1C8F2F12;
      e_b2b  = 32'hD4C3B2A1;
      e_wrap = 32'h88776655;
      e_rst  = 32'h3E6F9618;
`endif
      wexp[0] = 16'hFFFE; wexp[1] = 16'hFFFF;
      wexp[2] = 16'h0000; wexp[3] = 16'h0001;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      mem[16'h0010] = 8'h12; mem[16'h0011] = 8'h2F;
      mem[16'h0012] = 8'h8F; mem[16'h0013] = 8'h1C;
      mem[16'h0020] = 8'hA1; mem[16'h0021] = 8'hB2;
      mem[16'h0022] = 8'hC3; mem[16'h0023] = 8'hD4;
      mem[16'hFFFE] = 8'h55; mem[16'hFFFF] = 8'h66;
      mem[16'h0000] = 8'h77; mem[16'h0001] = 8'h88;
      mem[16'h0030] = 8'h18; mem[16'h0031] = 8'h96;
      mem[16'h0032] = 8'h6F; mem[16'h0033] = 8'h3E;
      reset_n = 1'b0;
      bus.start = 1'b0;
      bus.base_addr = '0;
      bus.const_ready = 1'b0;
      step();
      step();
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_rd", 32'(bus.mem_rd), 32'd0);
      chk("rst_valid", 32'(bus.const_valid), 32'd0);
      chk("rst_addr", 32'(bus.mem_addr), 32'd0);
      chk("rst_out", bus.const_out, 32'd0);
      reset_n = 1'b1;
      step();

      // basic fetch with the consumer ready
      alog.delete();
      r0 = rd_cnt;
      c0 = cyc;
      bus.const_ready = 1'b1;
      bus.base_addr = 16'h0010;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      bus.base_addr = 16'h0BAD;
      wait_valid();
      chk("le_word", bus.const_out, e_le);
      chk("rd_count", 32'(rd_cnt - r0), 32'd4);
      for (int i = 0; i < 4; i++)
         chk("le_addr", 32'(alog[i]), 32'(16'h0010 + 16'(i)));
      chk("latency", 32'(vrise[$] - (c0 + 1)), 32'd4);
      step();
      chk("valid_one_cycle", 32'(bus.const_valid), 32'd0);
      chk("idle_busy", 32'(bus.busy), 32'd0);

      // backpressure: start must be ignored while not ready
      bus.const_ready = 1'b0;
      bus.base_addr = 16'h0020;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      wait_valid();
      held = bus.const_out;
      chk("bp_word", held, e_b2b);
      r0 = rd_cnt;
      for (int i = 0; i < 6; i++) begin
         bus.base_addr = 16'h0040 + 16'(i);
         bus.start = 1'b1;
         step();
         chk("bp_valid", 32'(bus.const_valid), 32'd1);
         chk("bp_hold", bus.const_out, held);
      end
      chk("bp_no_rd", 32'(rd_cnt - r0), 32'd0);
      bus.start = 1'b0;
      bus.const_ready = 1'b1;
      step();
      chk("bp_idle", 32'(bus.busy), 32'd0);
      chk("bp_keep_out", bus.const_out, held);

      // back-to-back fetch at the transfer edge
      bus.const_ready = 1'b0;
      bus.base_addr = 16'h0010;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      wait_valid();
      v1 = vrise[$];
      bus.base_addr = 16'h0020;
      bus.start = 1'b1;
      bus.const_ready = 1'b1;
      step();
      bus.start = 1'b0;
      chk("b2b_rd", 32'(bus.mem_rd), 32'd1);
      chk("b2b_addr", 32'(bus.mem_addr), 32'h0020);
      wait_valid();
      chk("b2b_period", 32'(vrise[$] - v1), 32'd5);
      chk("b2b_word", bus.const_out, e_b2b);
      step();

      // address wrap
      alog.delete();
      bus.base_addr = 16'hFFFE;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      wait_valid();
      chk("wrap_reads", 32'(alog.size()), 32'd4);
      for (int i = 0; i < 4 && i < alog.size(); i++)
         chk("wrap_addr", 32'(alog[i]), 32'(wexp[i]));
      chk("wrap_word", bus.const_out, e_wrap);
      step();

      // reset during the third read
      bus.base_addr = 16'h0020;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      step();
      chk("pre_rst_addr", 32'(bus.mem_addr), 32'h0022);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_rd", 32'(bus.mem_rd), 32'd0);
      chk("mid_rst_valid", 32'(bus.const_valid), 32'd0);
      chk("mid_rst_addr", 32'(bus.mem_addr), 32'd0);
      chk("mid_rst_out", bus.const_out, 32'd0);
      step();
      step();
      reset_n = 1'b1;
      nr = vrise.size();
      repeat (4) step();
      chk("no_valid_after_rst", 32'(vrise.size()), 32'(nr));
      chk("rst_idle", 32'(bus.busy), 32'd0);
      bus.base_addr = 16'h0030;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      wait_valid();
      chk("rst_refetch", bus.const_out, e_rst);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mconst_fetch.md
# mconst_fetch

Multi-beat constant fetch controller for the `MCONST` micro-block. It reads a 32-bit immediate from byte-wide program memory as four consecutive byte reads and assembles the word. It then presents the word on a valid/ready handshake toward the `MCONST` input. It sits between the fetch stage's byte memory port and the mblock constant path, and sequences every constant load.

## Interface
Parameters:
- `ADDR_WIDTH`, default 16: byte address width of program memory.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a fetch; sampled only in IDLE, and in HOLD together with `const_ready`.
- `base_addr`  in  `ADDR_WIDTH`: byte address of byte 0; latched when `start` is accepted.
- `busy`  out  1: high in any state except IDLE.
- `mem_rd`  out  1: memory read strobe.
- `mem_addr`  out  `ADDR_WIDTH`: read address; meaningful only while `mem_rd` is high.
- `mem_data`  in  8: read data, valid exactly one cycle after the matching `mem_rd`.
- `const_out`  out  32: assembled constant, feeding `MCONST.in`.
- `const_valid`  out  1: `const_out` is complete and held.
- `const_ready`  in  1: consumer accepts the constant.

## Operation
States:
- IDLE: waits for a request.
- FETCH: one counter, `k` = 0..4.
- HOLD: presents the constant.

Transitions:
- **IDLE, `start`=1:** latch `base_addr` and go to FETCH with `k`=0. IDLE with `start`=0 stays in IDLE.
- **FETCH, reads:** while `k` is 0..3, drive `mem_rd`=1 and `mem_addr` = base+`k`.
- **FETCH, data capture:** when `k` is 1..4, capture `mem_data` as byte `k`-1. Reads and captures are pipelined at one byte per cycle.
- **FETCH exit:** after capturing byte 3 (`k`=4), go to HOLD.
- **HOLD, `const_ready`=1 and `start`=0:** go to IDLE.
- **HOLD, `const_ready`=1 and `start`=1:** back-to-back fetch. Latch the new `base_addr` and go straight to FETCH with `k`=0.
- **HOLD, `const_ready`=0:** stay in HOLD. `const_out` is stable.

Rules:
- `start` is ignored in FETCH, and ignored in HOLD unless `const_ready`=1.
- Address arithmetic is modulo 2^`ADDR_WIDTH`. Example: base = all-ones wraps to 0, 1, 2 for bytes 1..3.
- Default byte order is little-endian: the byte at base+0 goes to `const_out[7:0]` and the byte at base+3 goes to `const_out[31:24]`.
- `const_out` is updated only by byte captures. Otherwise it keeps its last value, including after the handshake and in IDLE.
- `const_valid` is high only in HOLD.

Reset (`reset_n` low, at any time, including mid-FETCH or in HOLD):
- State returns to IDLE.
- `busy`, `mem_rd`, `const_valid` = 0.
- `mem_addr` and `const_out` = 0.
- An aborted fetch never raises `const_valid`, and partial bytes are discarded.
- After reset release, the first `start` is accepted at the first rising edge at which `reset_n` is high.

## Timing
- `start` is accepted at edge E0.
- Reads: `mem_rd` is high for exactly 4 cycles, following edges E0..E3, with addresses base..base+3.
- Captures: bytes are captured at edges E1..E4.
- `const_valid` rises after E4. Fetch latency is 4 cycles from acceptance to valid.
- A transfer occurs at an edge where both `const_valid` and `const_ready` are high.
- With a back-to-back `start` at that edge:
  - `mem_rd` resumes in the very next cycle.
  - Minimum period is 5 cycles per constant.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro `MCONST_FETCH_BIG_ENDIAN_EN`.
- **Defined:** the byte at base+0 goes to `const_out[31:24]` and the byte at base+3 goes to `const_out[7:0]`. Read order, addresses and timing are unchanged.
- **Undefined:** little-endian assembly as described in Operation.

## Test plan
- **Little-endian fetch:** memory holds 0x12, 0x2F, 0x8F, 0x1C at 0x0010..0x0013; `start` with base 0x0010 and `const_ready`=1 → `mem_rd` for 4 cycles on 0x0010..0x0013, then `const_valid` for 1 cycle with `const_out`=0x1C8F2F12.
- **Big-endian build:** same stimulus with `MCONST_FETCH_BIG_ENDIAN_EN` defined → `const_out`=0x122F8F1C.
- **Backpressure:** hold `const_ready`=0 for 6 cycles after valid, pulsing `start` with other bases → `const_valid` stays high, `const_out` is unchanged, no extra `mem_rd`; `const_ready`=1 → IDLE with `busy`=0.
- **Back-to-back:** `start` with base 0x0020 asserted together with `const_ready` in HOLD → `mem_rd` on 0x0020 in the next cycle; the second valid comes exactly 5 cycles after the first.
- **Address wrap:** `ADDR_WIDTH`=16, base 0xFFFE → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- **Reset mid-fetch:** assert `reset_n`=0 during the third read → all outputs 0 immediately; after release there is no `const_valid` until a new `start`, and the next fetch of 0x3E6F9618 completes correctly.
